shifter_pipe: RTL
=================

# shifter_pipe

Parametrised, pipelined barrel shifter for the Mini-MIPS execute stage, succeeding the combinational 32-bit shifter. It supports logical/arithmetic shifts and rotates on a WIDTH-bit operand, with carry-out and zero flags. Latency is a configurable number of register stages, and a valid/ready handshake allows the writeback side to stall it. A TAG field travels with each operation so the issuing logic can match results to destination registers.

## Interface
- WIDTH, 32, operand width; power of two, 8..64.
- PIPE, 2, register stages; 1..log2(WIDTH).
- TAGW, 5, tag width (destination register index).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation present on input.
- in_ready  output  1  block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  log2(WIDTH)  shift/rotate amount.
- in_mode  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others PASS.
- in_tag  input  TAGW  opaque tag, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_carry  output  1  last bit shifted or rotated across the boundary.
- out_zero  output  1  out_data == 0.
- out_tag  output  TAGW  tag of the result.

## Operation
- Log shifter: log2(WIDTH) mux levels, level k shifts by 2^k when shamt[k]=1.
  - Levels are split across PIPE stages, ceil(levels/PIPE) per stage; early stages take the extra level.
  - Each stage registers: partial data, remaining shamt bits, mode, tag, carry-so-far, valid.
- SLL: vacated bits 0.
- SRL: vacated bits 0.
- SRA: vacated bits copy in_data[WIDTH-1].
- ROL/ROR: bits wrap, none lost.
- PASS (modes 101..111): out_data = in_data, out_carry = 0.
- Carry when shamt=0: out_carry = 0.
- Carry when shamt≠0:
  - SLL: in_data[WIDTH-shamt].
  - SRL/SRA: in_data[shamt-1].
  - ROL: out_data[0].
  - ROR: out_data[WIDTH-1].
- out_zero is computed combinationally from out_data.
- Stall is global: advance = !out_valid || out_ready.
  - When advance=1, all stages shift forward; stage 0 loads in_valid/inputs.
  - When advance=0, all stage registers hold.
- in_ready = advance. The operation transfers when in_valid && in_ready.
- Bubbles (valid=0) move through stages like data. There is no bubble collapse.
- Outputs are driven directly from the final stage registers; there is no combinational path from inputs to outputs.

## Timing
- Latency: an op accepted at edge N appears on out_valid after edge N+PIPE-1 (visible in cycle N+PIPE-1..N+PIPE window).
  - Equivalently, out_valid rises PIPE cycles after the accepting cycle.
- Throughput: 1 op/cycle while out_ready=1.
- Backpressure: in_ready follows out_ready combinationally whenever out_valid=1.
  - in_ready=1 whenever out_valid=0, even if upstream stages are full. Accepting into a non-empty pipeline is legal because the final stage is empty and everything moves.
- Held outputs: while out_valid=1 && out_ready=0, out_data/out_carry/out_zero/out_tag stay stable.
- Reset values: all valid bits 0, all data/tag/carry registers 0.
  - Hence out_valid=0, out_data=0, out_carry=0, out_zero=1, out_tag=0, in_ready=1.
- Reset mid-operation flushes every in-flight op. No result for them ever appears.
- Input accepted in the same cycle as rst is discarded.
- Simultaneous final-stage drain and input accept in one cycle is legal; neither op is lost or duplicated.
- shamt ≥ WIDTH is impossible by width. shamt=WIDTH-1 is the maximum and is exercised.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1. Required: out_valid=0, in_ready=1, out_zero=1, and no output appears afterwards.
- Modes, WIDTH=32, PIPE=2, in_data=0x8000_0001, shamt=4, back-to-back over 5 cycles. Required results, each after 2 cycles:
  - SLL → 0x0000_0010, carry 0.
  - SRL → 0x0800_0000, carry 0.
  - SRA → 0xF800_0000, carry 0.
  - ROL → 0x0000_0018, carry 0.
  - ROR → 0x1800_0000, carry 0.
- Carry and boundaries:
  - SLL 0xFFFF_FFFF by 31 → 0x8000_0000, carry 1.
  - SRA 0x8000_0000 by 31 → 0xFFFF_FFFF, carry 0.
  - SRL 0x0000_0001 by 1 → 0, carry 1, zero 1.
  - Any mode with shamt=0 → data unchanged, carry 0.
- Backpressure: stream 8 tagged ops (tags 1..8) while toggling out_ready randomly. Required: results in order, tags 1..8 each exactly once, outputs stable while stalled, in_ready==(!out_valid||out_ready).
- Reset mid-stream: with 2 ops in flight, pulse rst for 1 cycle. Required: neither op emerges; the next op accepted after reset returns with correct data after PIPE cycles.
- Parametrisation: repeat the mode test with WIDTH=8, PIPE=1 and WIDTH=64, PIPE=6. Required: latency equals PIPE and results match a reference model on 1000 random ops.

Source files
------------

// File: rtl/shifter_pipe.sv
// Pipelined log barrel shifter (SLL/SRL/SRA/ROL/ROR/PASS) with carry, zero flag and tag; PIPE-cycle latency.
// Global stall: every stage holds while the final result is valid and out_ready is low; in_ready mirrors that.
module shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2,
    parameter int TAGW  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [2:0]               in_mode,
    input  logic [TAGW-1:0]          in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic [TAGW-1:0]          out_tag
);
    localparam int LOGW = $clog2(WIDTH);
    localparam int LPS  = (LOGW + PIPE - 1) / PIPE;

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    typedef struct packed {
        logic            vld;
        logic [WIDTH-1:0] dat;
        logic [LOGW-1:0] shamt;
        logic [2:0]      mode;
        logic [TAGW-1:0] tag;
        logic            carry;
    } stage_t;

    stage_t           stage_in [PIPE];
    stage_t           stage_d  [PIPE];
    stage_t           stage_q  [PIPE];
    logic             advance;
    logic [WIDTH-1:0] spill;
    logic [LOGW-1:0]  sh_bits;
    int               sh;

    assign advance = !stage_q[PIPE-1].vld || out_ready;

    always_comb begin
        stage_in[0] = '{vld: in_valid, dat: in_data, shamt: in_shamt,
                        mode: in_mode, tag: in_tag, carry: 1'b0};
        for (int s = 1; s < PIPE; s++) begin
            stage_in[s] = stage_q[s-1];
        end
    end

    // Level k shifts by 2^k; the carry is refreshed by every level that actually
    // moves data, so after the last applied level it names the final boundary bit.
    always_comb begin
        spill   = '0;
        sh_bits = '0;
        sh      = 0;
        for (int s = 0; s < PIPE; s++) begin
            stage_d[s] = stage_in[s];
            for (int lvl = s * LPS; lvl < (s + 1) * LPS && lvl < LOGW; lvl++) begin
                sh_bits = stage_d[s].shamt >> lvl;
                if (sh_bits[0] && stage_d[s].mode <= MODE_ROR) begin
                    sh = 1 << lvl;
                    case (stage_d[s].mode)
                        MODE_SLL: begin
                            spill             = stage_d[s].dat >> (WIDTH - sh);
                            stage_d[s].carry  = spill[0];
                            stage_d[s].dat    = stage_d[s].dat << sh;
                        end
                        MODE_SRL: begin
                            spill             = stage_d[s].dat >> (sh - 1);
                            stage_d[s].carry  = spill[0];
                            stage_d[s].dat    = stage_d[s].dat >> sh;
                        end
                        MODE_SRA: begin
                            spill             = stage_d[s].dat >> (sh - 1);
                            stage_d[s].carry  = spill[0];
                            stage_d[s].dat    = $unsigned($signed(stage_d[s].dat) >>> sh);
                        end
                        MODE_ROL: begin
                            stage_d[s].dat    = (stage_d[s].dat << sh) | (stage_d[s].dat >> (WIDTH - sh));
                            stage_d[s].carry  = stage_d[s].dat[0];
                        end
                        MODE_ROR: begin
                            stage_d[s].dat    = (stage_d[s].dat >> sh) | (stage_d[s].dat << (WIDTH - sh));
                            stage_d[s].carry  = stage_d[s].dat[WIDTH-1];
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE; s++) begin
                stage_q[s] <= '0;
            end
        end else if (advance) begin
            for (int s = 0; s < PIPE; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = stage_q[PIPE-1].vld;
    assign out_data  = stage_q[PIPE-1].dat;
    assign out_carry = stage_q[PIPE-1].carry;
    assign out_tag   = stage_q[PIPE-1].tag;
    assign out_zero  = (out_data == '0);

endmodule
